dmux_stream: RTL and testbench

DMUX_STREAM -- requirements
Module: dmux_stream

---
 rtl/dmux_pkg.sv | 11 +
 rtl/dmux_fifo2.sv | 72 +++++++
 rtl/dmux_stream.sv | 60 ++++++
 tb/tb_dmux_stream.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/dmux_pkg.sv
// Shared constants for the two-channel stream demultiplexer.
// Holds the default word width, the fixed queue depth and the channel select encodings.
package dmux_pkg;

  localparam int DMUX_WIDTH = 16;
  localparam int DMUX_DEPTH = 2;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/dmux_fifo2.sv
// Two-entry queue with a 2-bit occupancy counter and 1-bit wrapping read/write pointers.
// push/pop are ignored when the queue is full/empty; head reads 0 while empty.
module dmux_fifo2
  import dmux_pkg::*;
#(
  parameter int WIDTH = DMUX_WIDTH,
  parameter int DEPTH = DMUX_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam logic [1:0] FULL_CNT = 2'(DEPTH);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == 2'd0);
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    push_ok  = push && !full;
    pop_ok   = pop && !empty;

    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    // Push and pop together keep occupancy unchanged.
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/dmux_stream.sv
// Routes an input stream word to one of two 2-entry output queues selected by in_sel.
// Handshake: a transfer happens on a rising edge where valid=1 and ready=1; ready never depends on valid.
module dmux_stream
  import dmux_pkg::*;
#(
  parameter int WIDTH = DMUX_WIDTH,
  parameter int DEPTH = DMUX_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready
);

  logic a_full, a_empty, b_full, b_empty;
  logic push_a, push_b, pop_a, pop_b;
  logic in_fire;

  // Fullness is taken before any same-cycle pop, so a full queue blocks input even while draining.
  assign in_ready = (in_sel == SEL_B) ? !b_full : !a_full;
  assign in_fire  = in_valid && in_ready;
  assign push_a   = in_fire && (in_sel == SEL_A);
  assign push_b   = in_fire && (in_sel == SEL_B);

  assign a_valid  = !a_empty;
  assign b_valid  = !b_empty;
  assign pop_a    = a_valid && a_ready;
  assign pop_b    = b_valid && b_ready;

  dmux_fifo2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_a),
    .push_data (in_data),
    .pop       (pop_a),
    .full      (a_full),
    .empty     (a_empty),
    .head      (a_data)
  );

  dmux_fifo2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_b),
    .push_data (in_data),
    .pop       (pop_b),
    .full      (b_full),
    .empty     (b_empty),
    .head      (b_data)
  );

endmodule

// File: tb/tb_dmux_stream.sv
// Directed self-checking bench for dmux_stream: reset, routing, backpressure,
// push/pop overlap, interleaved channels and mid-traffic reset.
module tb_dmux_stream;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;

  int checks;
  int failures;

  dmux_stream #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic sel, input logic [WIDTH-1:0] data);
    in_sel   = sel;
    in_data  = data;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    in_data  = '0;
    in_sel   = 1'b0;
    in_valid = 1'b0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;

    // reset state
    check("rst_a_valid", 32'(a_valid), 32'd0);
    check("rst_b_valid", 32'(b_valid), 32'd0);
    check("rst_a_data", 32'(a_data), 32'd0);
    check("rst_b_data", 32'(b_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // single word to a, one-cycle latency
    push_word(1'b0, 16'h00AA);
    check("lat_a_valid", 32'(a_valid), 32'd1);
    check("lat_a_data", 32'(a_data), 32'h00AA);
    check("lat_b_valid", 32'(b_valid), 32'd0);
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    check("pop_a_valid", 32'(a_valid), 32'd0);
    check("pop_a_data", 32'(a_data), 32'd0);
    // ready on an empty queue is harmless
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    check("empty_pop_a_valid", 32'(a_valid), 32'd0);

    // fill b, in_ready follows in_sel
    push_word(1'b1, 16'h0001);
    push_word(1'b1, 16'h0002);
    check("full_b_valid", 32'(b_valid), 32'd1);
    check("full_b_head", 32'(b_data), 32'h0001);
    in_sel  = 1'b1;
    in_data = 16'h0003;
    #1;
    check("full_b_in_ready_sel1", 32'(in_ready), 32'd0);
    in_sel = 1'b0;
    #1;
    check("full_b_in_ready_sel0", 32'(in_ready), 32'd1);

    // full b: pop and offered push together -> pop only
    in_sel   = 1'b1;
    in_data  = 16'h0003;
    in_valid = 1'b1;
    b_ready  = 1'b1;
    #1;
    check("full_pop_in_ready", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    b_ready  = 1'b0;
    #1;
    check("after_pop_in_ready", 32'(in_ready), 32'd1);
    check("after_pop_b_data", 32'(b_data), 32'h0002);
    b_ready = 1'b1;
    tick();
    b_ready = 1'b0;
    check("b_drained_valid", 32'(b_valid), 32'd0);
    check("a_untouched_valid", 32'(a_valid), 32'd0);

    // simultaneous push/pop on a single-entry queue
    push_word(1'b0, 16'h0010);
    check("a_one_data", 32'(a_data), 32'h0010);
    in_sel   = 1'b0;
    in_data  = 16'h0020;
    in_valid = 1'b1;
    a_ready  = 1'b1;
    tick();
    in_valid = 1'b0;
    a_ready  = 1'b0;
    #1;
    check("pushpop_a_valid", 32'(a_valid), 32'd1);
    check("pushpop_a_data", 32'(a_data), 32'h0020);
    a_ready = 1'b1;
    tick();
    a_ready = 1'b0;
    check("pushpop_a_single", 32'(a_valid), 32'd0);

    // interleaved channels with both consumers ready
    a_ready = 1'b1;
    b_ready = 1'b1;
    push_word(1'b0, 16'd1);
    check("il1_a_data", 32'(a_data), 32'd1);
    check("il1_b_valid", 32'(b_valid), 32'd0);
    push_word(1'b1, 16'd2);
    check("il2_b_data", 32'(b_data), 32'd2);
    check("il2_a_valid", 32'(a_valid), 32'd0);
    push_word(1'b0, 16'd3);
    check("il3_a_data", 32'(a_data), 32'd3);
    check("il3_b_valid", 32'(b_valid), 32'd0);
    push_word(1'b1, 16'd4);
    check("il4_b_data", 32'(b_data), 32'd4);
    check("il4_a_valid", 32'(a_valid), 32'd0);
    tick();
    check("il_end_b_valid", 32'(b_valid), 32'd0);
    a_ready = 1'b0;
    b_ready = 1'b0;

    // fill both queues, then reset with a word offered
    push_word(1'b0, 16'h0005);
    push_word(1'b0, 16'h0006);
    push_word(1'b1, 16'h0007);
    push_word(1'b1, 16'h0008);
    check("fill_a_head", 32'(a_data), 32'h0005);
    check("fill_b_head", 32'(b_data), 32'h0007);
    in_sel = 1'b0;
    #1;
    check("fill_in_ready", 32'(in_ready), 32'd0);
    rst_n    = 1'b0;
    in_sel   = 1'b1;
    in_data  = 16'h0009;
    in_valid = 1'b1;
    tick();
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_sel   = 1'b0;
    #1;
    check("post_rst_a_valid", 32'(a_valid), 32'd0);
    check("post_rst_b_valid", 32'(b_valid), 32'd0);
    check("post_rst_a_data", 32'(a_data), 32'd0);
    check("post_rst_b_data", 32'(b_data), 32'd0);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
